// File: rtl/dp_pkg.sv
// Shared definitions for the chunked dot-product controller: element width,
// FSM state encoding, the partial-width rule and the saturating accumulate.
package dp_pkg;

  localparam int ELEM_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Exact width of a sum of SIZE products of two ELEM_W-bit unsigned values.
  function automatic int partWidth(input int size);
    return 2 * ELEM_W + $clog2(size);
  endfunction

  // Adds two values that fit in w bits. Bits [w-1:0] of the result hold the
  // sum clamped to 2^w-1, and bit w is set only when clamping happened, so a
  // caller can take a (w+1)-bit slice and get both the value and the flag.
  function automatic logic [64:0] satAdd(input logic [63:0] a,
                                         input logic [63:0] b,
                                         input int unsigned w);
    logic [64:0] sum;
    logic [64:0] maxVal;
    sum    = {1'b0, a} + {1'b0, b};
    maxVal = (65'd1 << w) - 65'd1;
    if (sum > maxVal) begin
      return maxVal | (65'd1 << w);
    end
    return sum;
  endfunction

endpackage

// File: rtl/dot_product_chunk.sv
// One datapath word of the dot product: sums SIZE lane products at full
// width, so no information is lost before the accumulator sees it.
module dot_product_chunk
  import dp_pkg::*;
#(
  parameter  int SIZE   = 4,
  localparam int PART_W = partWidth(SIZE)
) (
  input  logic [ELEM_W*SIZE-1:0] a,
  input  logic [ELEM_W*SIZE-1:0] b,
  output logic [PART_W-1:0]      partial
);

  // Sum the unsigned lane products; each product is widened before multiply.
  always_comb begin
    partial = '0;
    for (int i = 0; i < SIZE; i++) begin
      partial = partial + PART_W'(a[ELEM_W*i +: ELEM_W]) * PART_W'(b[ELEM_W*i +: ELEM_W]);
    end
  end

endmodule

// File: rtl/dot_product_ctrl.sv
// Job sequencer for a dot product longer than one datapath word: takes `len`
// chunks over a valid/ready stream, accumulates the chunk partials with
// saturation and hands the final sum out on a valid/ready result port.
// Every output is taken straight from registered state.
module dot_product_ctrl
  import dp_pkg::*;
#(
  parameter  int SIZE       = 4,
  parameter  int MAX_CHUNKS = 16,
  parameter  int ACC_W      = 24,
  localparam int LEN_W      = $clog2(MAX_CHUNKS + 1),
  localparam int PART_W     = partWidth(SIZE)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [LEN_W-1:0]       len,
  input  logic                   clear,
  output logic                   busy,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ELEM_W*SIZE-1:0] in_a,
  input  logic [ELEM_W*SIZE-1:0] in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       out_result,
  output logic                   out_ovf
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_CHUNKS);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovf_q, ovf_d;

  logic [PART_W-1:0]  partial;
  logic [ACC_W:0]     satRes;
  logic [LEN_W-1:0]   lenClamped;

  dot_product_chunk #(
    .SIZE(SIZE)
  ) uChunk (
    .a      (in_a),
    .b      (in_b),
    .partial(partial)
  );

  assign satRes     = (ACC_W + 1)'(satAdd(64'(acc_q), 64'(partial), ACC_W));
  assign lenClamped = (len > MAX_LEN) ? MAX_LEN : len;

  // State, accumulator, counter and latched length registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic; clear overrides every handshake and start.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
            if (lenClamped != '0) begin
              len_d   = lenClamped;
              state_d = RUN;
            end else begin
              state_d = DONE;
            end
          end
        end
        RUN: begin
          if (in_valid) begin
            acc_d = satRes[ACC_W-1:0];
            ovf_d = ovf_q | satRes[ACC_W];
            cnt_d = cnt_q + LEN_W'(1);
            if (cnt_q == len_q - LEN_W'(1)) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy       = (state_q != IDLE);
  assign in_ready   = (state_q == RUN);
  assign out_valid  = (state_q == DONE);
  assign out_result = acc_q;
  assign out_ovf    = ovf_q;

endmodule
